pc_fetch_unit: RTL and testbench
================================

Name: pc_fetch_unit

Overview:
- Program-counter and instruction-fetch stage directly downstream of the per-class control-word decoders.
- Consumes the decoded PC fields (Psel, PCsel, EN_PC), the 64-bit constant K and nextState from the active decoder.
- Holds PC, the instruction register (IR) and the 2-bit control state register.
- Feeds the instruction and state back to the decoders, and drives the instruction-memory address.

Parameters:
RESET_PC, 64'h0, PC value loaded on reset; bits [1:0] must be 0.
PC_STEP, 4, byte increment per sequential instruction.

Ports:
clock  in  1  system clock; all state updates on rising edge
reset_n  in  1  asynchronous, active-low reset
stall  in  1  1 = freeze PC, IR, state and sticky flag this cycle
Psel  in  2  PC update mode (see Behaviour)
PCsel  in  1  PC operand select: 0 = A_in, 1 = K
EN_PC  in  1  1 = drive pc_link onto pc_bus
K  in  64  constant from the decoder (sign-extended offset or absolute value)
A_in  in  64  register-file A bus
nextState  in  2  next control state from the decoder
imem_data  in  32  instruction word read at address pc
pc  out  64  current PC; also the instruction-memory address
pc_link  out  64  pc + PC_STEP, combinational
pc_bus  out  64  pc_link when EN_PC = 1, else 64'h0
instruction  out  32  IR contents
state  out  2  current control state
misaligned  out  1  sticky flag: a PC load was attempted with operand bits [1:0] != 0

Behaviour:
- Reset (reset_n = 0, asynchronous): pc = RESET_PC, instruction = 32'h0, state = 2'b00, misaligned = 0.
- While reset_n = 0, all registered outputs hold their reset values.
- Deassertion takes effect at the first rising edge with reset_n = 1.
- Reset asserted mid-operation overrides any pending update in the same cycle.
- Operand: op = PCsel ? K : A_in.
- PC update modes, one-cycle latency, registered:
  - Psel 00: hold, pc <= pc.
  - Psel 01: absolute load, pc <= {op[63:2], 2'b00}.
  - Psel 10: sequential, pc <= pc + PC_STEP.
  - Psel 11: relative, pc <= pc + PC_STEP + (op << 2).
- Arithmetic is 64-bit, modulo 2^64; wrap-around is silent, with no flag.
- The op << 2 product discards op[63:62]; op is signed two's complement, so negative K branches backward.
- Misaligned: set when Psel = 01 and op[1:0] != 0; stays set until reset. The masked load still happens.
- Relative mode cannot misalign, because pc is always word-aligned.
- IR: loaded with imem_data on the rising edge where state == 00 (fetch); held otherwise.
- state <= nextState every non-stalled edge. Encodings 01–11 are passed through unchanged.
- stall = 1 takes priority over every update: pc, instruction, state and misaligned all hold.
- Combinational outputs still track current values during stall.
- pc_link and pc_bus are combinational from pc; they update in the same cycle pc changes.
- No X propagation: undefined Psel cannot occur, since all 4 codes are defined.

Test Plan:
- Reset: reset_n low with pc at 0x40 -> pc = RESET_PC (0x0), state = 00, instruction = 0, misaligned = 0, immediately, without a clock edge.
- Sequential fetch: state 00, Psel = 10, imem_data = 0x14000003, nextState = 00, 3 edges -> pc = 0x0C; instruction = 0x14000003 after the first edge.
- Relative branch: pc = 0x100, Psel = 11, PCsel = 1, K = 0xFFFF_FFFF_FFFF_FFFE (-2) -> pc = 0xFC after one edge. With K = 3 -> pc = 0x110.
- Absolute load and misalignment: Psel = 01, PCsel = 0, A_in = 0x2003 -> pc = 0x2000, misaligned = 1.
  - A following aligned load of 0x3000 leaves misaligned = 1 until reset.
- Stall and wrap: pc = 0xFFFF_FFFF_FFFF_FFFC, Psel = 10, stall = 1 -> pc unchanged.
  - Release stall -> pc = 0x0.
  - With EN_PC = 1, pc_bus = pc_link = 0x0 in the wrap cycle; with EN_PC = 0, pc_bus = 0.
- IR gating: state = 01, new imem_data 0xDEADBEEF -> instruction unchanged. Return to state 00 -> loaded on the next edge.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// Program counter and instruction-fetch stage: holds PC, the instruction register
// and the 2-bit control state, and drives the instruction-memory address.
module pc_fetch_unit #(
   parameter logic [63:0] RESET_PC = 64'h0,
   parameter int unsigned PC_STEP  = 4
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        stall,
   input  logic [1:0]  Psel,
   input  logic        PCsel,
   input  logic        EN_PC,
   input  logic [63:0] K,
   input  logic [63:0] A_in,
   input  logic [1:0]  nextState,
   input  logic [31:0] imem_data,
   output logic [63:0] pc,
   output logic [63:0] pc_link,
   output logic [63:0] pc_bus,
   output logic [31:0] instruction,
   output logic [1:0]  state,
   output logic        misaligned
);

   typedef enum logic [1:0] {
      ST_FETCH = 2'b00,
      ST_1     = 2'b01,
      ST_2     = 2'b10,
      ST_3     = 2'b11
   } ctrl_state_t;

   ctrl_state_t state_q;
   logic [63:0] step;
   logic [63:0] op;
   logic [63:0] pc_next;
   logic        load_misaligned;

   assign step    = 64'(PC_STEP);
   assign pc_link = pc + step;
   assign pc_bus  = EN_PC ? pc_link : '0;
   assign state   = state_q;

   always_comb begin
      op              = PCsel ? K : A_in;
      pc_next         = pc;
      load_misaligned = 1'b0;
      unique case (Psel)
         2'b00: pc_next = pc;
         2'b01: begin
            pc_next         = {op[63:2], 2'b00};
            load_misaligned = (op[1:0] != 2'b00);
         end
         2'b10: pc_next = pc_link;
         2'b11: pc_next = pc_link + {op[61:0], 2'b00};
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         pc          <= RESET_PC;
         instruction <= '0;
         state_q     <= ST_FETCH;
         misaligned  <= 1'b0;
      end else if (!stall) begin
         pc      <= pc_next;
         state_q <= ctrl_state_t'(nextState);
         if (state_q == ST_FETCH)
            instruction <= imem_data;
         // sticky until reset; the masked load above still happens
         if (load_misaligned)
            misaligned <= 1'b1;
      end
   end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed plan checks with literal expectations plus
// randomized traffic compared each cycle against an arithmetic reference model.
module tb_pc_fetch_unit;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        stall;
   logic [1:0]  Psel;
   logic        PCsel;
   logic        EN_PC;
   logic [63:0] K;
   logic [63:0] A_in;
   logic [1:0]  nextState;
   logic [31:0] imem_data;
   logic [63:0] pc;
   logic [63:0] pc_link;
   logic [63:0] pc_bus;
   logic [31:0] instruction;
   logic [1:0]  state;
   logic        misaligned;

   int checks   = 0;
   int failures = 0;

   // reference model state
   logic [63:0] m_pc;
   logic [31:0] m_ir;
   logic [1:0]  m_st;
   logic        m_mis;

   pc_fetch_unit #(.RESET_PC(64'h0), .PC_STEP(4)) dut (
      .clock(clock), .reset_n(reset_n), .stall(stall), .Psel(Psel), .PCsel(PCsel),
      .EN_PC(EN_PC), .K(K), .A_in(A_in), .nextState(nextState), .imem_data(imem_data),
      .pc(pc), .pc_link(pc_link), .pc_bus(pc_bus), .instruction(instruction),
      .state(state), .misaligned(misaligned)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] model_next_pc(input logic [63:0] cur, input logic [1:0] mode,
                                                 input logic [63:0] opnd);
      case (mode)
         2'd0:    return cur;
         2'd1:    return opnd - (opnd % 64'd4);
         2'd2:    return cur + 64'd4;
         default: return cur + 64'd4 + opnd * 64'd4;
      endcase
   endfunction

   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         m_pc  <= 64'h0;
         m_ir  <= 32'h0;
         m_st  <= 2'd0;
         m_mis <= 1'b0;
      end else if (!stall) begin
         m_pc <= model_next_pc(m_pc, Psel, PCsel ? K : A_in);
         m_st <= nextState;
         if (m_st == 2'd0) m_ir <= imem_data;
         if (Psel == 2'd1 && ((PCsel ? K : A_in) % 64'd4) != 64'd0) m_mis <= 1'b1;
      end
   end

   always @(negedge clock) begin
      check("pc",          pc, m_pc);
      check("pc_link",     pc_link, m_pc + 64'd4);
      check("pc_bus",      pc_bus, EN_PC ? m_pc + 64'd4 : 64'h0);
      check("instruction", 64'(instruction), 64'(m_ir));
      check("state",       64'(state), 64'(m_st));
      check("misaligned",  64'(misaligned), 64'(m_mis));
   end

   task automatic drive(input logic [1:0] ps, input logic pcs, input logic [63:0] k,
                        input logic [63:0] a, input logic [1:0] ns, input logic [31:0] im);
      Psel = ps; PCsel = pcs; K = k; A_in = a; nextState = ns; imem_data = im;
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   initial begin
      reset_n = 1'b0; stall = 1'b0; EN_PC = 1'b0;
      drive(2'd0, 1'b0, 64'h0, 64'h0, 2'd0, 32'h0);
      #1;
      check("rst_pc", pc, 64'h0);
      tick();
      reset_n = 1'b1;

      // async reset from pc = 0x40, state = 01
      drive(2'd1, 1'b0, 64'h0, 64'h40, 2'd1, 32'h0);
      tick();
      check("load_40", pc, 64'h40);
      check("state_01", 64'(state), 64'd1);
      drive(2'd2, 1'b0, 64'h0, 64'h0, 2'd0, 32'h0);
      #1;
      reset_n = 1'b0;
      #1;
      check("async_pc", pc, 64'h0);
      check("async_state", 64'(state), 64'd0);
      check("async_ir", 64'(instruction), 64'd0);
      check("async_mis", 64'(misaligned), 64'd0);
      tick();
      check("held_pc", pc, 64'h0);
      reset_n = 1'b1;

      // sequential fetch
      drive(2'd2, 1'b0, 64'h0, 64'h0, 2'd0, 32'h14000003);
      tick();
      check("seq_ir", 64'(instruction), 64'h14000003);
      check("seq_pc1", pc, 64'h4);
      tick(); tick();
      check("seq_pc3", pc, 64'hC);

      // relative branches
      drive(2'd1, 1'b0, 64'h0, 64'h100, 2'd0, 32'h0);
      tick();
      drive(2'd3, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 64'h0, 2'd0, 32'h0);
      tick();
      check("rel_neg", pc, 64'hFC);
      drive(2'd1, 1'b0, 64'h0, 64'h100, 2'd0, 32'h0);
      tick();
      drive(2'd3, 1'b1, 64'h3, 64'h0, 2'd0, 32'h0);
      tick();
      check("rel_pos", pc, 64'h110);
      check("rel_mis", 64'(misaligned), 64'd0);

      // absolute load and sticky misalignment
      drive(2'd1, 1'b0, 64'h0, 64'h2003, 2'd0, 32'h0);
      tick();
      check("abs_pc", pc, 64'h2000);
      check("abs_mis", 64'(misaligned), 64'd1);
      drive(2'd1, 1'b0, 64'h0, 64'h3000, 2'd0, 32'h0);
      tick();
      check("abs_pc2", pc, 64'h3000);
      check("abs_sticky", 64'(misaligned), 64'd1);

      // stall and wrap-around
      drive(2'd1, 1'b0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFC, 2'd0, 32'h0);
      tick();
      drive(2'd2, 1'b0, 64'h0, 64'h0, 2'd0, 32'h0);
      stall = 1'b1;
      EN_PC = 1'b1;
      tick();
      check("stall_pc", pc, 64'hFFFF_FFFF_FFFF_FFFC);
      check("wrap_link", pc_link, 64'h0);
      check("wrap_bus_en", pc_bus, 64'h0);
      EN_PC = 1'b0;
      #1;
      check("wrap_bus_dis", pc_bus, 64'h0);
      stall = 1'b0;
      tick();
      check("wrap_pc", pc, 64'h0);
      EN_PC = 1'b1;
      #1;
      check("bus_after", pc_bus, 64'h4);

      // IR gating by control state
      drive(2'd0, 1'b0, 64'h0, 64'h0, 2'd1, 32'h1111_2222);
      tick();
      check("ir_fetch", 64'(instruction), 64'h1111_2222);
      drive(2'd0, 1'b0, 64'h0, 64'h0, 2'd1, 32'hDEADBEEF);
      tick();
      check("ir_hold", 64'(instruction), 64'h1111_2222);
      nextState = 2'd0;
      tick();
      check("ir_hold2", 64'(instruction), 64'h1111_2222);
      check("state_00", 64'(state), 64'd0);
      tick();
      check("ir_reload", 64'(instruction), 64'hDEADBEEF);

      // randomized traffic, checked each cycle by the compare process
      for (int i = 0; i < 3000; i++) begin
         Psel      = 2'($urandom_range(3));
         PCsel     = 1'($urandom_range(1));
         EN_PC     = 1'($urandom_range(1));
         stall     = ($urandom_range(7) == 0);
         nextState = 2'($urandom_range(3));
         imem_data = $urandom;
         if ($urandom_range(3) == 0) begin
            K    = {$urandom, $urandom};
            A_in = {$urandom, $urandom};
         end else begin
            K    = 64'($signed(12'($urandom)));
            A_in = 64'($urandom_range(4095));
         end
         if ($urandom_range(199) == 0) begin
            #1;
            reset_n = 1'b0;
            #1;
            check("rand_async_pc", pc, 64'h0);
            tick();
            reset_n = 1'b1;
         end else begin
            tick();
         end
      end

      @(negedge clock);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
